counter_updown_mod: RTL and testbench
=====================================

# counter_updown_mod

Parametrised synchronous up/down counter with programmable modulus, wrap or saturate mode, parallel load and an enable prescaler. It is the general-purpose successor to the fixed up-counter. It serves as the standard counting primitive for timers, address generators and event counters across the design. Single clock domain, synchronous active-high reset.

## Interface
- WIDTH, 4: counter width in bits.
- MODULUS, 16: count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2^WIDTH.
- SATURATE, 0: 0 = wrap at range ends, 1 = hold at range ends.
- PRESCALE, 1: number of enabled cycles per count step. Must be >= 1.

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  qualifies prescaler advance and counting.
- up_down  in  1  1 = count up, 0 = count down. Sampled every cycle.
- load  in  1  synchronous parallel load strobe.
- load_value  in  WIDTH  value to load.
- out  out  WIDTH  current count (registered).
- tc  out  1  terminal count (combinational from out and up_down).
- wrap  out  1  one-cycle pulse (registered) marking a wrap step.
- sat_flag  out  1  sticky flag: a step was blocked by saturation.

## Operation
- Priority per edge: reset > load > step.
- Reset state: out=0, wrap=0, sat_flag=0, prescaler count=0.
- Load:
  - out <= load_value, clamped to MODULUS-1 when load_value >= MODULUS.
  - Clears the prescaler count, wrap and sat_flag. No step occurs that cycle.
- Prescaler: internal count pcnt in 0..PRESCALE-1.
  - Advances only when enable=1.
  - step = enable && pcnt==PRESCALE-1; pcnt then returns to 0.
  - With PRESCALE=1, step = enable.
- Step, up:
  - out < MODULUS-1: out+1.
  - out = MODULUS-1: wraps to 0 and wrap<=1 (SATURATE=0), or holds and sat_flag<=1 (SATURATE=1).
- Step, down:
  - out > 0: out-1.
  - out = 0: wraps to MODULUS-1 with wrap<=1, or holds with sat_flag<=1.
- wrap is 0 on every edge not performing a wrap step. It is never asserted when SATURATE=1.
- tc = (up_down ? out==MODULUS-1 : out==0). It ignores enable and prescaler. During and after reset, tc=1 when up_down=0.
- Arithmetic is WIDTH bits wide. out never leaves 0..MODULUS-1, including when MODULUS=2^WIDTH (natural overflow path).
- Direction change mid-prescale does not reset pcnt. The next step uses the up_down value at the step edge.
- enable=0 freezes out and pcnt. It does not clear wrap; wrap still self-clears next cycle.

## Timing
- Latency 1 cycle: out reflects a load or step on the edge after the condition is sampled.
- wrap is high in the same cycle out first shows the wrapped value, for exactly one cycle.
- sat_flag is set on the edge of the blocked step. It stays high until reset or load.
- tc has a combinational path from up_down. Consumers register it if timing requires.
- Reset asserted mid-prescale or mid-count: all state returns to reset values on that edge, regardless of load or enable.
- Simultaneous load and step: load wins and the step is discarded.

## Structure
- Shared package counter_pkg:
  - DIR_UP=1'b1 and DIR_DOWN=1'b0 constants.
  - MODE_WRAP=0 and MODE_SAT=1 constants.
  - clamp function (value, modulus) for the load path.
- Sub-module tick_prescaler:
  - Parameter PRESCALE.
  - Ports clock, reset, enable, clear, tick.
  - Generates the step pulse. Clear is driven by load.
- Top level holds the count register, wrap/saturate logic, wrap and sat_flag registers, and the tc decode.

## Test plan
- Reset then count up (WIDTH=4, MODULUS=10, SATURATE=0, PRESCALE=1, enable=1, up_down=1): out 0,1,…,9,0. wrap=1 only on the cycle out=0 after 9; tc=1 while out=9.
- Count down from reset (same config, up_down=0): out 0→9→8. wrap pulses on the cycle out=9; tc=1 during reset and at out=0.
- Saturate (SATURATE=1, MODULUS=10, load 8, count up): out 8,9,9,9. sat_flag rises on the edge of the first blocked step; wrap stays 0; a later load of 3 gives out=3 and clears sat_flag.
- Prescaler (PRESCALE=3, enable toggled 1,1,0,1): out increments only on the third enabled cycle. A load mid-prescale restarts the 3-cycle count.
- Load clamp and priority (MODULUS=10): load_value=13 gives out=9. Load and step in the same cycle: load wins. Reset together with load gives out=0.
- Full-width wrap (WIDTH=4, MODULUS=16): up from 15 gives 0 with wrap=1; down from 0 gives 15 with wrap=1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    localparam int unsigned CLAMP_W = 32;

    // Limit a load value to the legal count range 0..modulus-1.
    function automatic logic [CLAMP_W-1:0] clamp(input logic [CLAMP_W-1:0] value,
                                                 input logic [CLAMP_W-1:0] modulus);
        logic [CLAMP_W-1:0] res;
        res = value;
        if (value >= modulus) begin
            res = modulus - CLAMP_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_updown_mod_tick_prescaler.sv
// Enable prescaler: emits one tick every PRESCALE enabled cycles.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;

    // With PRESCALE=1 LAST is 0, so pcnt stays at 0 and tick follows enable.
    assign tick = enable && (pcnt_q == LAST);

    always_comb begin
        pcnt_d = pcnt_q;
        if (clear) begin
            pcnt_d = '0;
        end else if (enable) begin
            pcnt_d = tick ? '0 : pcnt_q + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down modulus counter with wrap or saturate mode, parallel load and prescaled enable.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             sat_flag
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             tick;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .clear  (load),
        .tick   (tick)
    );

    // Next count: load wins over a step; range ends either wrap or hold.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        sat_d  = sat_q;
        if (load) begin
            cnt_d = WIDTH'(clamp(CLAMP_W'(load_value), CLAMP_W'(MODULUS)));
            sat_d = 1'b0;
        end else if (tick) begin
            if (up_down == DIR_UP) begin
                if (cnt_q == MAX_VAL) begin
                    if (SATURATE == MODE_SAT) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    if (SATURATE == MODE_SAT) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d  = MAX_VAL;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end

    assign out      = cnt_q;
    assign wrap     = wrap_q;
    assign sat_flag = sat_q;
    assign tc       = (up_down == DIR_UP) ? (cnt_q == MAX_VAL) : (cnt_q == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: four configurations share one stimulus stream and a modulo-arithmetic model.
module tb_counter_updown_mod;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [3:0] load_value;

    logic [3:0] out_v  [4];
    logic       tc_v   [4];
    logic       wrap_v [4];
    logic       sat_v  [4];

    // Instance order: A wrap M10, B saturate M10, C prescale-3 M10, D full-width M16.
    int mod_p [4] = '{10, 10, 10, 16};
    int sat_p [4] = '{0, 1, 0, 0};
    int pre_p [4] = '{1, 1, 3, 1};

    int m_cnt  [4];
    int m_pc   [4];
    int m_wrap [4];
    int m_sat  [4];

    int n_pass  = 0;
    int n_total = 0;

    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_a (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .out(out_v[0]), .tc(tc_v[0]), .wrap(wrap_v[0]), .sat_flag(sat_v[0]));
    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) u_b (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .out(out_v[1]), .tc(tc_v[1]), .wrap(wrap_v[1]), .sat_flag(sat_v[1]));
    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) u_c (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .out(out_v[2]), .tc(tc_v[2]), .wrap(wrap_v[2]), .sat_flag(sat_v[2]));
    counter_updown_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(1)) u_d (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .out(out_v[3]), .tc(tc_v[3]), .wrap(wrap_v[3]), .sat_flag(sat_v[3]));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: count range as modular arithmetic; a step fires every pre-th enabled cycle.
    initial begin
        int at_end;
        forever begin
            @(posedge clock);
            for (int i = 0; i < 4; i++) begin
                if (reset) begin
                    m_cnt[i] = 0; m_pc[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
                end else if (load) begin
                    m_cnt[i]  = (int'(load_value) >= mod_p[i]) ? mod_p[i] - 1 : int'(load_value);
                    m_pc[i]   = 0;
                    m_wrap[i] = 0;
                    m_sat[i]  = 0;
                end else begin
                    m_wrap[i] = 0;
                    if (enable) begin
                        m_pc[i] = (m_pc[i] + 1) % pre_p[i];
                        if (m_pc[i] == 0) begin
                            at_end = up_down ? int'(m_cnt[i] == mod_p[i] - 1) : int'(m_cnt[i] == 0);
                            if (at_end != 0 && sat_p[i] != 0) begin
                                m_sat[i] = 1;
                            end else begin
                                m_cnt[i]  = (m_cnt[i] + (up_down ? 1 : mod_p[i] - 1)) % mod_p[i];
                                m_wrap[i] = at_end;
                            end
                        end
                    end
                end
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                check($sformatf("model out[%0d]", i), int'(out_v[i]), m_cnt[i]);
                check($sformatf("model wrap[%0d]", i), int'(wrap_v[i]), m_wrap[i]);
                check($sformatf("model sat[%0d]", i), int'(sat_v[i]), m_sat[i]);
                check($sformatf("model tc[%0d]", i), int'(tc_v[i]),
                      up_down ? int'(m_cnt[i] == mod_p[i] - 1) : int'(m_cnt[i] == 0));
            end
        end
    end

    // Apply inputs now, return at the next falling edge with outputs settled.
    task automatic drive(input logic r, input logic e, input logic ud, input logic ld,
                         input logic [3:0] lv);
        reset = r; enable = e; up_down = ud; load = ld; load_value = lv;
        @(negedge clock);
    endtask

    initial begin
        drive(1, 1, 1, 0, 0);
        drive(1, 1, 1, 0, 0);
        check("rst A out", int'(out_v[0]), 0);
        check("rst A wrap", int'(wrap_v[0]), 0);
        check("rst B sat", int'(sat_v[1]), 0);
        check("rst A tc up", int'(tc_v[0]), 0);
        drive(1, 1, 0, 0, 0);
        check("rst A tc down", int'(tc_v[0]), 1);

        for (int k = 0; k < 9; k++) drive(0, 1, 1, 0, 0);
        check("up A out9", int'(out_v[0]), 9);
        check("up A tc9", int'(tc_v[0]), 1);
        check("up C out", int'(out_v[2]), 3);
        drive(0, 1, 1, 0, 0);
        check("up A wrap out", int'(out_v[0]), 0);
        check("up A wrap", int'(wrap_v[0]), 1);
        check("up B hold", int'(out_v[1]), 9);
        check("up B sat", int'(sat_v[1]), 1);
        check("up B nowrap", int'(wrap_v[1]), 0);
        check("up D out", int'(out_v[3]), 10);
        drive(0, 1, 1, 0, 0);
        check("up A wrap clr", int'(wrap_v[0]), 0);

        drive(1, 1, 0, 0, 0);
        check("dn rst tc", int'(tc_v[0]), 1);
        drive(0, 1, 0, 0, 0);
        check("dn A out", int'(out_v[0]), 9);
        check("dn A wrap", int'(wrap_v[0]), 1);
        check("dn D out", int'(out_v[3]), 15);
        check("dn D wrap", int'(wrap_v[3]), 1);
        check("dn B sat0", int'(sat_v[1]), 1);
        drive(0, 1, 0, 0, 0);
        check("dn A out8", int'(out_v[0]), 8);
        check("dn A wrap0", int'(wrap_v[0]), 0);

        drive(0, 1, 1, 1, 8);
        check("sat B load8", int'(out_v[1]), 8);
        check("sat B clr", int'(sat_v[1]), 0);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        check("sat B hold", int'(out_v[1]), 9);
        check("sat B flag", int'(sat_v[1]), 1);
        drive(0, 1, 1, 0, 0);
        check("sat B nowrap", int'(wrap_v[1]), 0);
        drive(0, 1, 1, 1, 3);
        check("sat B load3", int'(out_v[1]), 3);
        check("sat B flag clr", int'(sat_v[1]), 0);

        drive(0, 0, 1, 1, 0);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        check("pre C hold", int'(out_v[2]), 0);
        drive(0, 1, 1, 0, 0);
        check("pre C step", int'(out_v[2]), 1);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 1, 5);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        check("pre C restart", int'(out_v[2]), 5);
        drive(0, 1, 1, 0, 0);
        check("pre C after3", int'(out_v[2]), 6);

        drive(0, 1, 1, 1, 13);
        check("clamp A", int'(out_v[0]), 9);
        check("clamp D", int'(out_v[3]), 13);
        drive(0, 1, 1, 1, 4);
        check("load beats step", int'(out_v[0]), 4);
        drive(1, 1, 1, 1, 7);
        check("rst beats load A", int'(out_v[0]), 0);
        check("rst beats load D", int'(out_v[3]), 0);

        drive(0, 1, 1, 1, 15);
        check("full D load", int'(out_v[3]), 15);
        check("full D tc", int'(tc_v[3]), 1);
        drive(0, 1, 1, 0, 0);
        check("full D wrap out", int'(out_v[3]), 0);
        check("full D wrap", int'(wrap_v[3]), 1);
        drive(0, 0, 1, 0, 0);
        check("full D wrap selfclr", int'(wrap_v[3]), 0);
        check("full D frozen", int'(out_v[3]), 0);

        // Mixed sweep: direction flips mid-prescale, enable gaps, loads and a reset.
        for (int i = 0; i < 60; i++) begin
            drive(logic'(i == 45), logic'((i % 5) != 3), logic'(((i / 7) % 2) == 0),
                  logic'(i == 20 || i == 33), 4'(i % 16));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
